// File: rtl/serial_store_unit.sv
// Bit-serial store unit: assembles an LSB-first address and data stream, then issues
// one lane-replicated, byte-masked write to the memory port (SB/SH/SW).
module serial_store_unit #(
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2:0]         func,
   input  logic               bit_in,
   input  logic               bit_valid,
   output logic               busy,
   output logic [5:0]         bit_pos,
   output logic               mem_en,
   output logic [A_WIDTH-1:0] mem_addr,
   output logic [D_WIDTH-1:0] mem_data,
   output logic [3:0]         mem_mask,
   output logic               done,
   output logic               misaligned
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADDR  = 2'd1,
      S_DATA  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   localparam logic [2:0] F_SB = 3'b000;
   localparam logic [2:0] F_SH = 3'b001;
   localparam logic [2:0] F_SW = 3'b010;
   localparam int         AW   = A_WIDTH + 2;

   state_t               state_q, state_d;
   logic [2:0]           func_q, func_d;
   // Only the byte-address bits that reach the port are kept; upper bits wrap away.
   logic [AW-1:0]        addr_q, addr_d;
   logic [D_WIDTH-1:0]   data_q, data_d;
   logic [5:0]           bit_pos_q, bit_pos_d;
   logic                 fault_q, fault_d;
   logic                 mem_en_q, mem_en_d;
   logic [A_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [D_WIDTH-1:0]   mem_data_q, mem_data_d;
   logic [3:0]           mem_mask_q, mem_mask_d;
   logic                 done_q, done_d;
   logic                 misaligned_q, misaligned_d;

   logic                 func_ok;
   logic                 last_bit;
   logic [D_WIDTH-1:0]   lane_data;
   logic [3:0]           lane_mask;

   assign func_ok  = (func_q == F_SB) || (func_q == F_SH) || (func_q == F_SW);
   assign last_bit = bit_valid && (bit_pos_q == 6'd31);

   always_comb begin
      state_d      = state_q;
      func_d       = func_q;
      addr_d       = addr_q;
      data_d       = data_q;
      bit_pos_d    = bit_pos_q;
      fault_d      = fault_q;
      mem_en_d     = 1'b0;
      mem_mask_d   = 4'b0000;
      done_d       = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      misaligned_d = misaligned_q;
      lane_data    = '0;
      lane_mask    = 4'b0000;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               func_d       = func;
               misaligned_d = 1'b0;
               fault_d      = 1'b0;
               bit_pos_d    = 6'd0;
               state_d      = S_ADDR;
            end
         end

         S_ADDR: begin
            if (bit_valid) begin
               for (int i = 0; i < AW; i++) begin
                  if (bit_pos_q == 6'(i)) addr_d[i] = bit_in;
               end
               if (last_bit) begin
                  bit_pos_d = 6'd0;
                  state_d   = S_DATA;
                  fault_d   = ((func_q == F_SH) && addr_d[0]) ||
                              ((func_q == F_SW) && (addr_d[1:0] != 2'b00));
               end else begin
                  bit_pos_d = bit_pos_q + 6'd1;
               end
            end
         end

         S_DATA: begin
            if (bit_valid) begin
               data_d[bit_pos_q[4:0]] = bit_in;
               if (last_bit) begin
                  bit_pos_d = 6'd0;
                  state_d   = S_WRITE;
                  case (func_q)
                     F_SB: begin
                        lane_data = {4{data_d[7:0]}};
                        lane_mask = 4'b0001 << addr_q[1:0];
                     end
                     F_SH: begin
                        lane_data = {2{data_d[15:0]}};
                        lane_mask = 4'b0011 << addr_q[1:0];
                     end
                     default: begin
                        lane_data = data_d;
                        lane_mask = 4'b1111;
                     end
                  endcase
                  // Outputs are registered on entry so they are valid during WRITE.
                  mem_addr_d = addr_q[AW-1:2];
                  mem_data_d = lane_data;
                  done_d     = 1'b1;
                  if (func_ok) begin
                     if (fault_q) begin
                        misaligned_d = 1'b1;
                     end else begin
                        mem_en_d   = 1'b1;
                        mem_mask_d = lane_mask;
                     end
                  end
               end else begin
                  bit_pos_d = bit_pos_q + 6'd1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         func_q       <= 3'b000;
         addr_q       <= '0;
         data_q       <= '0;
         bit_pos_q    <= 6'd0;
         fault_q      <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         mem_mask_q   <= 4'b0000;
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         func_q       <= func_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         bit_pos_q    <= bit_pos_d;
         fault_q      <= fault_d;
         mem_en_q     <= mem_en_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         mem_mask_q   <= mem_mask_d;
         done_q       <= done_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign bit_pos    = bit_pos_q;
   assign mem_en     = mem_en_q;
   assign mem_addr   = mem_addr_q;
   assign mem_data   = mem_data_q;
   assign mem_mask   = mem_mask_q;
   assign done       = done_q;
   assign misaligned = misaligned_q;

endmodule

// File: tb/tb_serial_store_unit.sv
// Directed bench for serial_store_unit: SB/SH/SW writes, faults, gaps, reset abort.
module tb_serial_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  func;
   logic        bit_in;
   logic        bit_valid;
   logic        busy;
   logic [5:0]  bit_pos;
   logic        mem_en;
   logic [9:0]  mem_addr;
   logic [31:0] mem_data;
   logic [3:0]  mem_mask;
   logic        done;
   logic        misaligned;

   int checks = 0;
   int errors = 0;

   // Values captured in the WRITE cycle by run_store
   int          w_cyc;
   logic        w_en;
   logic [9:0]  w_addr;
   logic [31:0] w_data;
   logic [3:0]  w_mask;
   logic        w_done;
   logic        w_mis;
   logic        w_busy_after;

   always #5 clk = ~clk;

   serial_store_unit #(.D_WIDTH(32), .A_WIDTH(10)) dut (
      .clk(clk), .rst(rst), .start(start), .func(func), .bit_in(bit_in),
      .bit_valid(bit_valid), .busy(busy), .bit_pos(bit_pos), .mem_en(mem_en),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_mask(mem_mask),
      .done(done), .misaligned(misaligned)
   );

   // Drives one complete store starting at the current negedge; records the WRITE cycle.
   task automatic run_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                            input bit toggle, input bit extra);
      logic [63:0] stream;
      int idx;
      stream = {d, a};
      idx = 0;
      w_cyc = -1;
      start = 1'b1;
      func = f;
      bit_valid = 1'b1;
      bit_in = 1'b1;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            w_cyc = n;
            w_en = mem_en; w_addr = mem_addr; w_data = mem_data;
            w_mask = mem_mask; w_done = done; w_mis = misaligned;
            break;
         end
         start = extra && (n % 10 == 5);
         if (extra) func = 3'b000;
         bit_valid = (!toggle || (n % 2 == 0)) && (idx < 64);
         bit_in = bit_valid ? stream[idx] : 1'b0;
         if (bit_valid) idx++;
      end
      start = 1'b0;
      bit_valid = 1'b0;
      bit_in = 1'b0;
      if (w_cyc >= 0) begin
         @(negedge clk);
         w_busy_after = busy;
      end else begin
         w_busy_after = 1'bx;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; func = 3'b000; bit_in = 1'b0; bit_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (bit_pos !== 6'd0) begin errors++; $display("FAIL reset_bit_pos got %0d exp 0", bit_pos); end
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b exp 0", mem_en); end
      checks++; if (mem_addr !== 10'd0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
      checks++; if (mem_data !== 32'd0) begin errors++; $display("FAIL reset_mem_data got %h exp 0", mem_data); end
      checks++; if (mem_mask !== 4'd0) begin errors++; $display("FAIL reset_mem_mask got %b exp 0", mem_mask); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned got %b exp 0", misaligned); end
   endtask

   task automatic test_sw();
      run_store(3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0);
      checks++; if (w_cyc !== 65) begin errors++; $display("FAIL sw_latency got %0d exp 65", w_cyc); end
      checks++; if (w_en !== 1'b1) begin errors++; $display("FAIL sw_en got %b exp 1", w_en); end
      checks++; if (w_addr !== 10'd4) begin errors++; $display("FAIL sw_addr got %h exp 004", w_addr); end
      checks++; if (w_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_data got %h exp deadbeef", w_data); end
      checks++; if (w_mask !== 4'b1111) begin errors++; $display("FAIL sw_mask got %b exp 1111", w_mask); end
      checks++; if (w_mis !== 1'b0) begin errors++; $display("FAIL sw_mis got %b exp 0", w_mis); end
      checks++; if (w_busy_after !== 1'b0) begin errors++; $display("FAIL sw_busy_after got %b exp 0", w_busy_after); end
      checks++; if (mem_en !== 1'b0 || done !== 1'b0 || mem_mask !== 4'd0) begin
         errors++; $display("FAIL sw_after_write en %b done %b mask %b exp 0 0 0000", mem_en, done, mem_mask); end
      checks++; if (mem_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_data_hold got %h exp deadbeef", mem_data); end
   endtask

   task automatic test_sb();
      run_store(3'b000, 32'h0000_0013, 32'h0000_00A5, 1'b0, 1'b0);
      checks++; if (w_cyc !== 65) begin errors++; $display("FAIL sb_latency got %0d exp 65", w_cyc); end
      checks++; if (w_en !== 1'b1) begin errors++; $display("FAIL sb_en got %b exp 1", w_en); end
      checks++; if (w_addr !== 10'd4) begin errors++; $display("FAIL sb_addr got %h exp 004", w_addr); end
      checks++; if (w_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_data got %h exp a5a5a5a5", w_data); end
      checks++; if (w_mask !== 4'b1000) begin errors++; $display("FAIL sb_mask got %b exp 1000", w_mask); end
   endtask

   task automatic test_sh();
      run_store(3'b001, 32'h0000_0006, 32'h0000_1234, 1'b0, 1'b0);
      checks++; if (w_en !== 1'b1) begin errors++; $display("FAIL sh_en got %b exp 1", w_en); end
      checks++; if (w_addr !== 10'd1) begin errors++; $display("FAIL sh_addr got %h exp 001", w_addr); end
      checks++; if (w_data !== 32'h1234_1234) begin errors++; $display("FAIL sh_data got %h exp 12341234", w_data); end
      checks++; if (w_mask !== 4'b1100) begin errors++; $display("FAIL sh_mask got %b exp 1100", w_mask); end
   endtask

   task automatic test_misaligned();
      run_store(3'b001, 32'h0000_0005, 32'h0000_BEEF, 1'b0, 1'b0);
      checks++; if (w_en !== 1'b0 || w_mask !== 4'd0) begin errors++; $display("FAIL sh_mis_write en %b mask %b exp 0 0000", w_en, w_mask); end
      checks++; if (w_done !== 1'b1 || w_cyc !== 65) begin errors++; $display("FAIL sh_mis_done cyc %0d exp 65", w_cyc); end
      checks++; if (w_mis !== 1'b1) begin errors++; $display("FAIL sh_mis_flag got %b exp 1", w_mis); end
      checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL sh_mis_sticky got %b exp 1", misaligned); end
      run_store(3'b010, 32'h0000_0002, 32'h1111_2222, 1'b0, 1'b0);
      checks++; if (w_en !== 1'b0 || w_mask !== 4'd0) begin errors++; $display("FAIL sw_mis_write en %b mask %b exp 0 0000", w_en, w_mask); end
      checks++; if (w_done !== 1'b1) begin errors++; $display("FAIL sw_mis_done got %b exp 1", w_done); end
      checks++; if (w_mis !== 1'b1) begin errors++; $display("FAIL sw_mis_flag got %b exp 1", w_mis); end
      start = 1'b1; func = 3'b010;
      @(negedge clk);
      start = 1'b0;
      checks++; if (misaligned !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL mis_clear_on_start mis %b busy %b exp 0 1", misaligned, busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_invalid_func();
      run_store(3'b011, 32'h0000_0008, 32'hCAFE_F00D, 1'b0, 1'b0);
      checks++; if (w_en !== 1'b0 || w_mask !== 4'd0) begin errors++; $display("FAIL inv_write en %b mask %b exp 0 0000", w_en, w_mask); end
      checks++; if (w_done !== 1'b1 || w_mis !== 1'b0) begin errors++; $display("FAIL inv_flags done %b mis %b exp 1 0", w_done, w_mis); end
   endtask

   task automatic test_gaps();
      run_store(3'b010, 32'h0000_1008, 32'h0BAD_F00D, 1'b1, 1'b1);
      checks++; if (w_cyc !== 129) begin errors++; $display("FAIL gap_latency got %0d exp 129", w_cyc); end
      checks++; if (w_en !== 1'b1) begin errors++; $display("FAIL gap_en got %b exp 1", w_en); end
      checks++; if (w_addr !== 10'h002) begin errors++; $display("FAIL gap_addr got %h exp 002", w_addr); end
      checks++; if (w_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL gap_data got %h exp 0badf00d", w_data); end
      checks++; if (w_mask !== 4'b1111) begin errors++; $display("FAIL gap_mask got %b exp 1111", w_mask); end
   endtask

   task automatic test_back_to_back();
      run_store(3'b000, 32'h0000_0021, 32'h0000_003C, 1'b0, 1'b0);
      checks++; if (w_mask !== 4'b0010 || w_addr !== 10'd8) begin errors++; $display("FAIL b2b_first mask %b addr %h exp 0010 008", w_mask, w_addr); end
      run_store(3'b001, 32'h0000_0022, 32'h0000_ABCD, 1'b0, 1'b0);
      checks++; if (w_cyc !== 65) begin errors++; $display("FAIL b2b_second_latency got %0d exp 65", w_cyc); end
      checks++; if (w_data !== 32'hABCD_ABCD || w_mask !== 4'b1100) begin errors++; $display("FAIL b2b_second data %h mask %b exp abcdabcd 1100", w_data, w_mask); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] stream;
      int en_seen;
      stream = {32'h5555_AAAA, 32'h0000_0040};
      start = 1'b1; func = 3'b010; bit_valid = 1'b0;
      for (int i = 0; i < 49; i++) begin
         @(negedge clk);
         start = 1'b0;
         bit_valid = 1'b1;
         bit_in = stream[i];
      end
      @(negedge clk);
      checks++; if (bit_pos !== 6'd17 || busy !== 1'b1) begin errors++; $display("FAIL mid_pos got %0d busy %b exp 17 1", bit_pos, busy); end
      rst = 1'b1; bit_in = stream[49];
      @(negedge clk);
      rst = 1'b0;
      checks++; if (busy !== 1'b0 || bit_pos !== 6'd0 || mem_en !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL mid_reset_ctrl busy %b pos %0d en %b done %b exp 0 0 0 0", busy, bit_pos, mem_en, done); end
      checks++; if (mem_addr !== 10'd0 || mem_data !== 32'd0 || mem_mask !== 4'd0 || misaligned !== 1'b0) begin
         errors++; $display("FAIL mid_reset_data addr %h data %h mask %b mis %b exp all 0", mem_addr, mem_data, mem_mask, misaligned); end
      en_seen = 0;
      for (int i = 50; i < 64; i++) begin
         bit_in = stream[i];
         @(negedge clk);
         if (mem_en === 1'b1 || done === 1'b1) en_seen++;
      end
      bit_valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (mem_en === 1'b1 || done === 1'b1) en_seen++;
      end
      checks++; if (en_seen !== 0) begin errors++; $display("FAIL mid_no_write got %0d pulses exp 0", en_seen); end
      run_store(3'b000, 32'h0000_0102, 32'h0000_0077, 1'b0, 1'b0);
      checks++; if (w_cyc !== 65 || w_en !== 1'b1) begin errors++; $display("FAIL post_reset_sb cyc %0d en %b exp 65 1", w_cyc, w_en); end
      checks++; if (w_addr !== 10'h040 || w_data !== 32'h7777_7777 || w_mask !== 4'b0100) begin
         errors++; $display("FAIL post_reset_sb_val addr %h data %h mask %b exp 040 77777777 0100", w_addr, w_data, w_mask); end
   endtask

   initial begin
      test_reset();
      test_sw();
      test_sb();
      test_sh();
      test_misaligned();
      test_invalid_func();
      test_gaps();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_store_unit.md
Name: serial_store_unit

Overview:
Bit-serial store path for the serial RISC-V datapath. It accepts an effective address and then store data as LSB-first bit streams produced by the ALU. It assembles both into words, then issues one masked write to the BlockRAM port with byte-lane replication and a mask for SB/SH/SW. Misaligned accesses are detected and suppressed, and the block reports completion to the Control_Unit.

Parameters:
D_WIDTH, 32, data word width; fixed at 32 (4 byte lanes).
A_WIDTH, 10, word-address width of the memory port.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin a store transaction; sampled only in IDLE.
func  input  3  funct3 captured on start: 000 SB, 001 SH, 010 SW; any other value is invalid.
bit_in  input  1  serial address/data bit, LSB first.
bit_valid  input  1  bit_in is valid this cycle.
busy  output  1  transaction in progress (state != IDLE).
bit_pos  output  6  index (0..31) of the next bit expected in the current phase.
mem_en  output  1  one-cycle write strobe to memory.
mem_addr  output  A_WIDTH  word address (addr[A_WIDTH+1:2]).
mem_data  output  32  lane-replicated write data.
mem_mask  output  4  byte write enables; bit n = byte n.
done  output  1  one-cycle completion pulse.
misaligned  output  1  sticky fault flag for the last transaction.

Behaviour:
- Reset: state IDLE; busy, bit_pos, mem_en, mem_addr, mem_data, mem_mask, done, misaligned all 0. The internal shift registers and captured func clear. Reset at any point, including mid-ADDR or mid-DATA, aborts the transaction with no write.
- States: IDLE -> ADDR -> DATA -> WRITE -> IDLE.
- IDLE:
  - start=1 captures func, clears misaligned, sets bit_pos=0 and goes to ADDR.
  - bit_valid is ignored in IDLE, including a bit presented in the same cycle as start.
- ADDR:
  - Each cycle with bit_valid=1 shifts bit_in into the address register at index bit_pos; bit_pos increments.
  - Cycles with bit_valid=0 hold all state (gaps allowed, no timeout).
  - On the 32nd accepted bit: bit_pos returns to 0, the state goes to DATA, and the alignment check is evaluated and registered.
- Alignment check: SH with addr[0]=1 -> fault; SW with addr[1:0]!=00 -> fault; SB never faults.
- DATA: same shift rules as ADDR into the data register. On the 32nd accepted bit, bit_pos returns to 0 and the state goes to WRITE.
- WRITE (exactly one cycle); done=1 in this cycle:
  - mem_addr = addr[A_WIDTH+1:2]. Upper address bits are discarded, so the address wraps modulo the memory size.
  - SB: mem_data = {4{d[7:0]}}, mem_mask = 0001 << addr[1:0].
  - SH: mem_data = {2{d[15:0]}}, mem_mask = 0011 << addr[1:0] (offset 0 or 2 only).
  - SW: mem_data = d, mem_mask = 1111.
  - If fault: mem_en=0, mem_mask=0000, misaligned=1.
  - If func is invalid: mem_en=0, mem_mask=0000, misaligned=0.
  - Otherwise: mem_en=1.
- Outputs outside WRITE: mem_en, mem_mask and done are 0 outside WRITE. mem_addr and mem_data hold their last values. misaligned holds until the next accepted start or reset.
- start while busy is ignored and does not re-capture func.
- Latency: with bit_valid continuously high from the cycle after start, WRITE occurs 65 cycles after the start cycle. busy falls the cycle after WRITE, and a new start is accepted in that cycle.
- The block is fully registered; there are no combinational paths from inputs to mem_* outputs.

Test Plan:
- SW, addr 0x00000010, data 0xDEADBEEF, continuous valid -> WRITE at cycle 65: mem_en=1, mem_addr=4, mem_data=0xDEADBEEF, mem_mask=1111, done=1, misaligned=0.
- SB, addr 0x00000013, data 0x000000A5 -> mem_addr=4, mem_data=0xA5A5A5A5, mem_mask=1000.
- SH, addr 0x00000006, data 0x00001234 -> mem_addr=1, mem_data=0x12341234, mem_mask=1100.
- SH, addr 0x00000005; then SW, addr 0x00000002 -> both: mem_en=0, mem_mask=0000, done pulses, misaligned=1. A following aligned SW start clears misaligned.
- SW, addr 0x00001008, bit_valid toggling 1/0 every cycle, plus start pulses mid-transaction -> extra starts ignored; WRITE at cycle 129; mem_addr=2 (wrapped); data written intact.
- rst asserted at data bit 17 of an SW -> next cycle all outputs 0, state IDLE, no mem_en. A fresh SB then completes normally.
